// File: rtl/formant_pkg.sv
// Shared types and default widths for the formant datapath sequencers.
package formant_pkg;

  localparam int unsigned DEF_BIT_WIDTH = 32;
  localparam int unsigned DEF_I         = 160;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    GAP
  } state_t;

endpackage

// File: rtl/emin_row_sched_if.sv
// Bundles the controller, Emin-unit and Emin-buffer signals of emin_row_sched.
interface emin_row_sched_if
  import formant_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int unsigned I         = DEF_I
);
  localparam int unsigned IW = $clog2(I);

  logic                 start_in;
  logic [IW-1:0]        first_i_in;
  logic [IW-1:0]        last_i_in;
  logic                 hold_in;
  logic [IW-1:0]        emin_i_out;
  logic                 emin_valid_out;
  logic                 emin_output_valid_in;
  logic [IW-1:0]        emin_j_in;
  logic [BIT_WIDTH-1:0] emin_data_in;
  logic                 emin_iter_done_in;
  logic                 wr_en_out;
  logic [IW-1:0]        wr_i_out;
  logic [IW-1:0]        wr_j_out;
  logic [BIT_WIDTH-1:0] wr_data_out;
  logic                 busy_out;
  logic                 done_out;
  logic                 err_out;

  // Scheduler side.
  modport slave (
    input  start_in, first_i_in, last_i_in, hold_in,
           emin_output_valid_in, emin_j_in, emin_data_in, emin_iter_done_in,
    output emin_i_out, emin_valid_out, wr_en_out, wr_i_out, wr_j_out,
           wr_data_out, busy_out, done_out, err_out
  );

  // Controller / Emin unit / buffer side.
  modport master (
    output start_in, first_i_in, last_i_in, hold_in,
           emin_output_valid_in, emin_j_in, emin_data_in, emin_iter_done_in,
    input  emin_i_out, emin_valid_out, wr_en_out, wr_i_out, wr_j_out,
           wr_data_out, busy_out, done_out, err_out
  );

endinterface

// File: rtl/emin_seq_check.sv
// Per-row j-sequence checker: expected-j counter plus final-j check; flags errors combinationally.
module emin_seq_check
  import formant_pkg::*;
#(
  parameter int unsigned I = DEF_I
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 i_clear,
  input  logic                 i_valid,
  input  logic                 i_iter_done,
  input  logic [$clog2(I)-1:0] i_j,
  input  logic [$clog2(I)-1:0] i_cur_i,
  output logic                 o_err
);

  logic [$clog2(I)-1:0] r_exp_j;

  always_ff @(posedge clk_in) begin
    if (rst_in || i_clear) begin
      r_exp_j <= '0;
    end else if (i_valid) begin
      r_exp_j <= r_exp_j + 1'b1;
    end
  end

  // A row-ending strobe without data, or ending on the wrong j, is a short/long row.
  always_comb begin
    o_err = 1'b0;
    if (i_valid && (i_j != r_exp_j)) begin
      o_err = 1'b1;
    end
    if (i_iter_done && (!i_valid || (i_j != i_cur_i))) begin
      o_err = 1'b1;
    end
  end

endmodule

// File: rtl/emin_row_sched.sv
// Emin row sequencer: launches rows first_i..last_i, registers buffer writes, tracks errors.
// Optional per-row watchdog enabled by defining EMIN_ROW_SCHED_WATCHDOG_EN.
module emin_row_sched
  import formant_pkg::*;
#(
  parameter int unsigned BIT_WIDTH       = DEF_BIT_WIDTH,
  parameter int unsigned I               = DEF_I,
  parameter int unsigned WATCHDOG_CYCLES = 4096
) (
  input logic             clk_in,
  input logic             rst_in,
  emin_row_sched_if.slave bus
);

  localparam int unsigned IW = $clog2(I);

  state_t               r_state;
  logic [IW-1:0]        r_cur_i;
  logic [IW-1:0]        r_last_i;
  logic                 r_emin_valid;
  logic                 r_wr_en;
  logic [IW-1:0]        r_wr_i;
  logic [IW-1:0]        r_wr_j;
  logic [BIT_WIDTH-1:0] r_wr_data;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;

  logic w_in_wait;
  logic w_launch;
  logic w_bad_range;
  logic w_stray;
  logic w_seq_err;
  logic w_wd_expire;

  assign w_in_wait   = (r_state == WAIT);
  assign w_launch    = (r_state == LAUNCH) && !bus.hold_in;
  assign w_bad_range = (bus.first_i_in > bus.last_i_in) || (32'(bus.last_i_in) >= I);
  assign w_stray     = bus.emin_output_valid_in && !w_in_wait;

  emin_seq_check #(
    .I(I)
  ) u_seq_check (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .i_clear     (w_launch),
    .i_valid     (w_in_wait && bus.emin_output_valid_in),
    .i_iter_done (w_in_wait && bus.emin_iter_done_in),
    .i_j         (bus.emin_j_in),
    .i_cur_i     (r_cur_i),
    .o_err       (w_seq_err)
  );

`ifdef EMIN_ROW_SCHED_WATCHDOG_EN
  localparam int unsigned WDW = $clog2(WATCHDOG_CYCLES + 1);
  logic [WDW-1:0] r_wd_cnt;

  always_ff @(posedge clk_in) begin
    if (rst_in || w_launch) begin
      r_wd_cnt <= '0;
    end else if (w_in_wait) begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  assign w_wd_expire = w_in_wait && (r_wd_cnt == WDW'(WATCHDOG_CYCLES - 1));
`else
  logic w_unused_wd;
  assign w_unused_wd = (WATCHDOG_CYCLES != 0);
  assign w_wd_expire = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state      <= IDLE;
      r_cur_i      <= '0;
      r_last_i     <= '0;
      r_emin_valid <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_i       <= '0;
      r_wr_j       <= '0;
      r_wr_data    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_emin_valid <= 1'b0;
      r_wr_en      <= 1'b0;
      r_done       <= 1'b0;
      if (w_seq_err || w_stray) begin
        r_err <= 1'b1;
      end
      unique case (r_state)
        IDLE: begin
          if (bus.start_in) begin
            if (w_bad_range) begin
              r_err  <= 1'b1;
              r_done <= 1'b1;
            end else begin
              // A stray result in the start cycle still wins over the clear.
              r_err    <= w_stray;
              r_cur_i  <= bus.first_i_in;
              r_last_i <= bus.last_i_in;
              r_busy   <= 1'b1;
              r_state  <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          if (!bus.hold_in) begin
            r_emin_valid <= 1'b1;
            r_state      <= WAIT;
          end
        end
        WAIT: begin
          if (bus.emin_output_valid_in) begin
            r_wr_en   <= 1'b1;
            r_wr_i    <= r_cur_i;
            r_wr_j    <= bus.emin_j_in;
            r_wr_data <= bus.emin_data_in;
          end
          if (bus.emin_iter_done_in) begin
            r_state <= GAP;
          end else if (w_wd_expire) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        GAP: begin
          if (r_cur_i == r_last_i) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cur_i <= r_cur_i + 1'b1;
            r_state <= LAUNCH;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.emin_i_out     = r_cur_i;
  assign bus.emin_valid_out = r_emin_valid;
  assign bus.wr_en_out      = r_wr_en;
  assign bus.wr_i_out       = r_wr_i;
  assign bus.wr_j_out       = r_wr_j;
  assign bus.wr_data_out    = r_wr_data;
  assign bus.busy_out       = r_busy;
  assign bus.done_out       = r_done;
  assign bus.err_out        = r_err;

endmodule

// File: tb/tb_emin_row_sched.sv
// Scoreboard bench for emin_row_sched: behavioural Emin unit model plus write monitor.
// The watchdog scenario runs only when EMIN_ROW_SCHED_WATCHDOG_EN is defined.
`timescale 1ns/1ps
module tb_emin_row_sched;
  import formant_pkg::*;

  localparam int unsigned BW = 32;
  localparam int unsigned NI = 160;
  localparam int unsigned IW = $clog2(NI);
  localparam int unsigned WD = 64;

  typedef struct {
    int          i;
    int          j;
    logic [31:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  emin_row_sched_if #(.BIT_WIDTH(BW), .I(NI)) bus ();

  emin_row_sched #(
    .BIT_WIDTH       (BW),
    .I               (NI),
    .WATCHDOG_CYCLES (WD)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_vec    = 0;
  int  n_err    = 0;
  int  n_launch = 0;
  int  n_wr     = 0;
  time t_launch = 0;
  time t_done   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every buffer write must match the oldest result the model issued.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.emin_valid_out) n_launch++;
      if (bus.wr_en_out) begin
        n_wr++;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_i", bus.wr_i_out, mon_e.i);
          chk("wr_j", bus.wr_j_out, mon_e.j);
          chk("wr_data", bus.wr_data_out, mon_e.d);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  task automatic pulse_start(input int first, input int last);
    @(negedge clk);
    bus.start_in   = 1'b1;
    bus.first_i_in = IW'(first);
    bus.last_i_in  = IW'(last);
    @(negedge clk);
    bus.start_in = 1'b0;
  endtask

  // Emin unit model. mode 0: j=0..row; 1: skip j=2; 2/3: two results, no iter_done.
  task automatic run_row(input int row, input int mode, input int bound);
    int js[$];
    bit seen = 1'b0;
    for (int j = 0; j <= row; j++) begin
      if (!(mode == 1 && j == 2)) js.push_back(j);
    end
    if (mode >= 2) begin
      while (js.size() > 2) void'(js.pop_back());
    end
    for (int k = 0; k < bound && !seen; k++) begin
      @(negedge clk);
      seen = bus.emin_valid_out;
    end
    chk("launch_seen", seen, 1);
    if (!seen) return;
    t_launch = $time;
    chk("launch_row", bus.emin_i_out, row);
    chk("busy_in_row", bus.busy_out, 1);
    @(negedge clk);
    chk("launch_one_cycle", bus.emin_valid_out, 0);
    for (int n = 0; n < js.size(); n++) begin
      int          gap = $urandom_range(0, 2);
      logic [31:0] d   = $urandom;
      repeat (gap) @(negedge clk);
      bus.emin_output_valid_in = 1'b1;
      bus.emin_j_in            = IW'(js[n]);
      bus.emin_data_in         = d;
      bus.emin_iter_done_in    = (mode < 2) && (n == js.size() - 1);
      exp_q.push_back('{row, js[n], d});
      @(negedge clk);
      bus.emin_output_valid_in = 1'b0;
      bus.emin_iter_done_in    = 1'b0;
    end
  endtask

  task automatic wait_done(input int bound);
    bit seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      @(negedge clk);
      seen = bus.done_out;
    end
    chk("done_seen", seen, 1);
    t_done = $time;
    @(negedge clk);
    chk("done_one_cycle", bus.done_out, 0);
    chk("busy_after_done", bus.busy_out, 0);
  endtask

  task automatic sweep(input int first, input int last, input int skip_row,
                       input int hold_row, input int exp_err);
    int base_wr = n_wr;
    int base_l  = n_launch;
    int exp_wr  = ((last + 1) * (last + 2)) / 2 - (first * (first + 1)) / 2;
    if (skip_row >= 2 && skip_row >= first && skip_row <= last) exp_wr--;
    pulse_start(first, last);
    chk("err_cleared_on_start", bus.err_out, 0);
    for (int r = first; r <= last; r++) begin
      run_row(r, (r == skip_row) ? 1 : 0, (r == hold_row + 1) ? 1 : 12);
      if (r == hold_row) begin
        int l0 = n_launch;
        bus.hold_in = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_launch_in_hold", n_launch - l0, 0);
        chk("busy_in_hold", bus.busy_out, 1);
        bus.hold_in = 1'b0;
      end
    end
    wait_done(10);
    chk("sweep_err", bus.err_out, exp_err);
    chk("sweep_launches", n_launch - base_l, last - first + 1);
    chk("sweep_writes", n_wr - base_wr, exp_wr);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic bad_start(input int first, input int last);
    int l0 = n_launch;
    pulse_start(first, last);
    chk("bad_done", bus.done_out, 1);
    chk("bad_err", bus.err_out, 1);
    chk("bad_busy", bus.busy_out, 0);
    @(negedge clk);
    chk("bad_done_one_cycle", bus.done_out, 0);
    repeat (5) @(negedge clk);
    chk("bad_no_launch", n_launch - l0, 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_emin_valid"}, bus.emin_valid_out, 0);
    chk({tag, "_emin_i"}, bus.emin_i_out, 0);
    chk({tag, "_wr_en"}, bus.wr_en_out, 0);
    chk({tag, "_wr_ij"}, {bus.wr_i_out, bus.wr_j_out}, 0);
    chk({tag, "_wr_data"}, bus.wr_data_out, 0);
    chk({tag, "_busy"}, bus.busy_out, 0);
    chk({tag, "_done"}, bus.done_out, 0);
    chk({tag, "_err"}, bus.err_out, 0);
  endtask

  initial begin
    bus.start_in             = 1'b0;
    bus.first_i_in           = '0;
    bus.last_i_in            = '0;
    bus.hold_in              = 1'b0;
    bus.emin_output_valid_in = 1'b0;
    bus.emin_j_in            = '0;
    bus.emin_data_in         = '0;
    bus.emin_iter_done_in    = 1'b0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b0;

    sweep(0, 3, -1, -1, 0);
    sweep(0, 3, -1, 1, 0);
    sweep(0, 3, 3, -1, 1);
    sweep(0, 3, -1, -1, 0);

    bad_start(5, 2);
    bad_start(0, 200);

    // Reset in the middle of row 2, then a one-row sweep.
    pulse_start(0, 3);
    run_row(0, 0, 12);
    run_row(1, 0, 12);
    run_row(2, 3, 12);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_outputs_zero("midrst");
    chk("midrst_queue", exp_q.size(), 0);
    repeat (4) @(negedge clk);
    chk("midrst_quiet", bus.emin_valid_out | bus.wr_en_out, 0);
    sweep(0, 0, -1, -1, 0);

    for (int t = 0; t < 4; t++) begin
      int f = $urandom_range(0, 6);
      sweep(f, f + $urandom_range(0, 5), -1, -1, 0);
    end

`ifdef EMIN_ROW_SCHED_WATCHDOG_EN
    begin
      int l0;
      pulse_start(7, 9);
      run_row(7, 2, 12);
      l0 = n_launch;
      wait_done(WD + 10);
      chk("wd_cycles", longint'((t_done - t_launch) / 10), WD);
      chk("wd_err", bus.err_out, 1);
      chk("wd_queue", exp_q.size(), 0);
      repeat (10) @(negedge clk);
      chk("wd_idle_no_launch", n_launch - l0, 0);
      sweep(2, 3, -1, -1, 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
